// File: rtl/seq_lock_pkg.sv
// Shared constants for the combination lock: FSM state encodings, default secret
// and a small sizing helper.
package seq_lock_pkg;

    localparam int unsigned DEF_SYM_W    = 3;
    localparam int unsigned DEF_CODE_LEN = 4;

    // Symbol 0 sits in the MSBs.
    localparam logic [DEF_CODE_LEN*DEF_SYM_W-1:0] DEFAULT_CODE = {3'd1, 3'd2, 3'd4, 3'd7};

    localparam int unsigned ST_W = 2;
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ENTRY    = 2'd1;
    localparam logic [1:0] ST_UNLOCKED = 2'd2;
    localparam logic [1:0] ST_LOCKOUT  = 2'd3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_lock_if.sv
// Switch/button inputs and status outputs of the combination lock.
interface seq_lock_if #(
    parameter int unsigned SYM_W = 3
);
    logic [SYM_W-1:0] sym;
    logic             enter;
    logic             unlock;
    logic             lockout;
    logic [3:0]       progress;
    logic [3:0]       fail_cnt;

    modport master (output sym, output enter,
                    input unlock, input lockout, input progress, input fail_cnt);
    modport slave  (input sym, input enter,
                    output unlock, output lockout, output progress, output fail_cnt);
endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every PSC_MAX clock cycles.
module tick_gen #(
    parameter int unsigned PSC_MAX = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int unsigned CNT_W = (PSC_MAX > 1) ? $clog2(PSC_MAX) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(PSC_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            r_tick <= w_wrap;
        end
    end

    assign tick = r_tick;
endmodule

// File: rtl/seq_lock.sv
// Sequential-code lock: synchronised switch/button entry, tick-timed unlock,
// entry timeout and lockout after repeated wrong codes.
module seq_lock
    import seq_lock_pkg::*;
#(
    parameter int unsigned                  SYM_W         = DEF_SYM_W,
    parameter int unsigned                  CODE_LEN      = DEF_CODE_LEN,
    parameter logic [CODE_LEN*SYM_W-1:0]    CODE          = DEFAULT_CODE,
    parameter int unsigned                  MAX_FAIL      = 3,
    parameter int unsigned                  PSC_MAX       = 50_000_000,
    parameter int unsigned                  UNLOCK_TICKS  = 5,
    parameter int unsigned                  LOCKOUT_TICKS = 10,
    parameter int unsigned                  TIMEOUT_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_lock_if.slave  lock_bus
);
    localparam int unsigned PROG_W = $clog2(CODE_LEN + 1);
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int unsigned DUR_W  = $clog2(max3(UNLOCK_TICKS, LOCKOUT_TICKS, TIMEOUT_TICKS) + 1);

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    logic [SYM_W-1:0]  r_sym_s1, r_sym_s2;
    logic              r_en_s1, r_en_s2, r_en_d;
    logic [1:0]        r_rdy;
    logic              r_armed;
    logic              w_press;
    logic              w_tick;
    logic [ST_W-1:0]   r_state, w_state_nxt;
    logic [PROG_W-1:0] r_progress, w_progress_nxt;
    logic              r_mismatch, w_mismatch_nxt;
    logic [FAIL_W-1:0] r_fail, w_fail_nxt, w_fail_inc;
    logic [DUR_W-1:0]  r_dur, w_dur_nxt;
    logic              r_unlock, r_lockout;
    logic [SYM_W-1:0]  w_exp_sym;
    logic              w_sym_bad;

    // Async assert, sync release of the internal reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Input synchronisers; r_armed blocks a button already held at reset release.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sym_s1 <= '0;
            r_sym_s2 <= '0;
            r_en_s1  <= 1'b0;
            r_en_s2  <= 1'b0;
            r_en_d   <= 1'b0;
            r_rdy    <= 2'b00;
            r_armed  <= 1'b0;
        end else begin
            r_sym_s1 <= lock_bus.sym;
            r_sym_s2 <= r_sym_s1;
            r_en_s1  <= lock_bus.enter;
            r_en_s2  <= r_en_s1;
            r_en_d   <= r_en_s2;
            r_rdy    <= {r_rdy[0], 1'b1};
            r_armed  <= r_armed | (r_rdy[1] & ~r_en_s2);
        end
    end
    assign w_press = r_armed & r_en_s2 & ~r_en_d;

    tick_gen #(.PSC_MAX(PSC_MAX)) u_tick (
        .clk   (clk),
        .rst_n (w_rst_n),
        .tick  (w_tick)
    );

    // Expected symbol for the current position (progress is 0 in IDLE).
    always_comb begin
        w_exp_sym = '0;
        for (int i = 0; i < int'(CODE_LEN); i++) begin
            if (r_progress == PROG_W'(i))
                w_exp_sym = CODE[(int'(CODE_LEN) - 1 - i) * int'(SYM_W) +: SYM_W];
        end
    end
    assign w_sym_bad  = (r_sym_s2 != w_exp_sym);
    assign w_fail_inc = (r_fail >= FAIL_W'(MAX_FAIL)) ? r_fail : r_fail + FAIL_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_progress_nxt = r_progress;
        w_mismatch_nxt = r_mismatch;
        w_fail_nxt     = r_fail;
        w_dur_nxt      = w_tick ? r_dur + DUR_W'(1) : r_dur;
        case (r_state)
            ST_IDLE: begin
                w_dur_nxt = '0;
                if (w_press) begin
                    w_state_nxt    = ST_ENTRY;
                    w_progress_nxt = PROG_W'(1);
                    w_mismatch_nxt = w_sym_bad;
                end
            end
            ST_ENTRY: begin
                if (r_progress == PROG_W'(CODE_LEN)) begin
                    w_progress_nxt = '0;
                    w_mismatch_nxt = 1'b0;
                    w_dur_nxt      = '0;
                    if (!r_mismatch) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_fail_nxt  = '0;
                    end else begin
                        w_fail_nxt  = w_fail_inc;
                        w_state_nxt = (w_fail_inc == FAIL_W'(MAX_FAIL)) ? ST_LOCKOUT : ST_IDLE;
                    end
                end else if (w_press) begin
                    // A press outranks a coincident tick and restarts the timeout.
                    w_progress_nxt = r_progress + PROG_W'(1);
                    w_mismatch_nxt = r_mismatch | w_sym_bad;
                    w_dur_nxt      = '0;
                end else if (w_tick && (r_dur == DUR_W'(TIMEOUT_TICKS - 1))) begin
                    w_state_nxt    = ST_IDLE;
                    w_progress_nxt = '0;
                    w_mismatch_nxt = 1'b0;
                    w_dur_nxt      = '0;
                end
            end
            ST_UNLOCKED: begin
                if (w_tick && (r_dur == DUR_W'(UNLOCK_TICKS - 1))) begin
                    w_state_nxt = ST_IDLE;
                    w_dur_nxt   = '0;
                end
            end
            ST_LOCKOUT: begin
                if (w_tick && (r_dur == DUR_W'(LOCKOUT_TICKS - 1))) begin
                    w_state_nxt = ST_IDLE;
                    w_fail_nxt  = '0;
                    w_dur_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_progress_nxt = '0;
                w_mismatch_nxt = 1'b0;
                w_dur_nxt      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_IDLE;
            r_progress <= '0;
            r_mismatch <= 1'b0;
            r_fail     <= '0;
            r_dur      <= '0;
            r_unlock   <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_progress <= w_progress_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_fail     <= w_fail_nxt;
            r_dur      <= w_dur_nxt;
            r_unlock   <= (w_state_nxt == ST_UNLOCKED);
            r_lockout  <= (w_state_nxt == ST_LOCKOUT);
        end
    end

    assign lock_bus.unlock   = r_unlock;
    assign lock_bus.lockout  = r_lockout;
    assign lock_bus.progress = 4'(r_progress);
    assign lock_bus.fail_cnt = 4'(r_fail);
endmodule

// File: tb/tb_seq_lock.sv
// Directed bench for seq_lock with a 4-cycle tick: vector table plus timing corner cases.
module tb_seq_lock;
    localparam int unsigned PSC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_lock_if #(.SYM_W(3)) bus ();

    seq_lock #(.PSC_MAX(PSC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lock_bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Length of the most recent high run of unlock / lockout, in clock cycles.
    int u_run = 0, l_run = 0, last_u = 0, last_l = 0;
    always @(posedge clk) begin
        if (bus.unlock) u_run++;
        else if (u_run != 0) begin last_u = u_run; u_run = 0; end
        if (bus.lockout) l_run++;
        else if (l_run != 0) begin last_l = l_run; l_run = 0; end
    end

    typedef struct {
        logic [2:0] sym;
        int         prog;
        int         fail;
        int         unl;
        int         lck;
        int         len;   // nonzero: wait for the state to end and check its tick length
    } vec_t;
    vec_t vecs[22];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Drive one button press; returns 4 cycles after progress has updated.
    task automatic press(input logic [2:0] s);
        @(negedge clk);
        bus.sym   = s;
        bus.enter = 1'b1;
        repeat (3) @(negedge clk);
        bus.enter = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic settle();
        int n = 0;
        while ((bus.unlock || bus.lockout) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("settle_bound", int'(n < 200), 1);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tcnt;
        vecs[0]  = '{3'd1, 1, 0, 0, 0, 0};
        vecs[1]  = '{3'd2, 2, 0, 0, 0, 0};
        vecs[2]  = '{3'd4, 3, 0, 0, 0, 0};
        vecs[3]  = '{3'd7, 0, 0, 1, 0, 5};
        vecs[4]  = '{3'd1, 1, 0, 0, 0, 0};
        vecs[5]  = '{3'd2, 2, 0, 0, 0, 0};
        vecs[6]  = '{3'd5, 3, 0, 0, 0, 0};
        vecs[7]  = '{3'd7, 0, 1, 0, 0, 0};
        vecs[8]  = '{3'd0, 1, 1, 0, 0, 0};
        vecs[9]  = '{3'd0, 2, 1, 0, 0, 0};
        vecs[10] = '{3'd0, 3, 1, 0, 0, 0};
        vecs[11] = '{3'd0, 0, 2, 0, 0, 0};
        vecs[12] = '{3'd7, 1, 2, 0, 0, 0};
        vecs[13] = '{3'd4, 2, 2, 0, 0, 0};
        vecs[14] = '{3'd2, 3, 2, 0, 0, 0};
        vecs[15] = '{3'd1, 0, 3, 0, 1, 0};
        vecs[16] = '{3'd1, 0, 3, 0, 1, 0};
        vecs[17] = '{3'd2, 0, 3, 0, 1, 10};
        vecs[18] = '{3'd1, 1, 0, 0, 0, 0};
        vecs[19] = '{3'd2, 2, 0, 0, 0, 0};
        vecs[20] = '{3'd4, 3, 0, 0, 0, 0};
        vecs[21] = '{3'd7, 0, 0, 1, 0, 5};

        bus.sym   = '0;
        bus.enter = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_unlock",   int'(bus.unlock),   0);
        chk("rst_lockout",  int'(bus.lockout),  0);
        chk("rst_progress", int'(bus.progress), 0);
        chk("rst_fail",     int'(bus.fail_cnt), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            press(vecs[i].sym);
            chk($sformatf("v%0d_progress", i), int'(bus.progress), vecs[i].prog);
            chk($sformatf("v%0d_fail",     i), int'(bus.fail_cnt), vecs[i].fail);
            chk($sformatf("v%0d_unlock",   i), int'(bus.unlock),   vecs[i].unl);
            chk($sformatf("v%0d_lockout",  i), int'(bus.lockout),  vecs[i].lck);
            if (vecs[i].len != 0) begin
                settle();
                if (vecs[i].unl != 0)
                    chk_rng($sformatf("v%0d_unlock_len", i), last_u,
                            4 * (vecs[i].len - 1) + 1, 4 * vecs[i].len);
                else
                    chk_rng($sformatf("v%0d_lockout_len", i), last_l,
                            4 * (vecs[i].len - 1) + 1, 4 * vecs[i].len);
                chk($sformatf("v%0d_post_fail", i), int'(bus.fail_cnt), 0);
            end
        end

        // Entry timeout leaves fail_cnt untouched.
        press(3'd1); press(3'd2); press(3'd5); press(3'd7);
        chk("to_pre_fail", int'(bus.fail_cnt), 1);
        press(3'd1); press(3'd2);
        chk("to_progress2", int'(bus.progress), 2);
        n = 0;
        while (bus.progress != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_rng("to_delay", n, 25, 28);
        chk("to_fail",    int'(bus.fail_cnt), 1);
        chk("to_lockout", int'(bus.lockout),  0);

        // Press landing on the 8th timeout tick is accepted.
        @(negedge clk);
        bus.sym   = 3'd1;
        bus.enter = 1'b1;
        repeat (3) @(negedge clk);
        bus.enter = 1'b0;
        chk("co_progress1", int'(bus.progress), 1);
        tcnt = 0;
        n    = 0;
        while (n < 100) begin
            if (dut.w_tick) tcnt++;
            if (tcnt == 7) break;
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        bus.sym   = 3'd2;
        bus.enter = 1'b1;
        repeat (2) @(negedge clk);
        chk("co_align_tick", int'(dut.w_tick), 1);
        @(negedge clk);
        chk("co_progress2", int'(bus.progress), 2);
        bus.enter = 1'b0;
        repeat (6) @(negedge clk);
        chk("co_progress_hold", int'(bus.progress), 2);
        n = 0;
        while (bus.progress != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("co_timeout_bound", int'(n < 100), 1);

        // Unlock asserts two cycles after the final press.
        press(3'd1); press(3'd2); press(3'd4);
        @(negedge clk);
        bus.sym   = 3'd7;
        bus.enter = 1'b1;
        repeat (3) @(negedge clk);
        chk("lat_progress4", int'(bus.progress), 4);
        chk("lat_unlock_early", int'(bus.unlock), 0);
        @(negedge clk);
        chk("lat_unlock", int'(bus.unlock), 1);
        chk("lat_fail", int'(bus.fail_cnt), 0);
        bus.enter = 1'b0;
        settle();

        // Async reset during lockout, with the button held across release.
        for (int k = 0; k < 3; k++) begin
            press(3'd0); press(3'd0); press(3'd0); press(3'd0);
        end
        chk("ar_lockout_on", int'(bus.lockout), 1);
        chk("ar_fail_sat",   int'(bus.fail_cnt), 3);
        @(negedge clk);
        bus.enter = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("ar_lockout",  int'(bus.lockout),  0);
        chk("ar_fail",     int'(bus.fail_cnt), 0);
        chk("ar_progress", int'(bus.progress), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_progress", int'(bus.progress), 0);
        bus.enter = 1'b0;
        repeat (3) @(negedge clk);
        press(3'd1);
        chk("after_held_progress", int'(bus.progress), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
